// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf interface: BFT packet field offsets,
// credit counter width and the per-port destination table entry.
package leaf_pkg;

    localparam int unsigned VALID_BIT   = 48;
    localparam int unsigned LEAF_LSB    = 43;
    localparam int unsigned PORT_LSB    = 39;
    localparam int unsigned ADDR_LSB    = 32;
    localparam int unsigned CREDIT_BITS = 8;

    typedef struct packed {
        logic [4:0] leaf;
        logic [3:0] dport;
        logic       configured;
    } dest_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: searches from ptr_i+1 (wrapping) and returns
// a one-hot grant for the first requester found.
module rr_arbiter #(
    parameter int unsigned N    = 3,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o
);

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = 32'(ptr_i) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req_i[PtrW'(idx)]) begin
                gnt_o[PtrW'(idx)] = 1'b1;
                found             = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter from user output streams into the BFT injection port;
// wraps each accepted word into a packet, gated by per-port credits.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int unsigned PACKET_BITS           = 49,
    parameter int unsigned PAYLOAD_BITS          = 32,
    parameter int unsigned NUM_LEAF_BITS         = 5,
    parameter int unsigned NUM_PORT_BITS         = 4,
    parameter int unsigned NUM_ADDR_BITS         = 7,
    parameter int unsigned NUM_OUT_PORTS         = 3,
    parameter int unsigned FREESPACE_UPDATE_SIZE = 64,
    parameter int unsigned CREDIT_INIT           = 128
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_wr,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dport,
    input  logic                                    credit_upd,
    input  logic [NUM_PORT_BITS-1:0]                credit_upd_port,
    input  logic                                    resend,
    input  logic                                    out_ready,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft
);

    localparam int unsigned PtrW = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam logic [CREDIT_BITS:0]   UpdAmt   = (CREDIT_BITS + 1)'(FREESPACE_UPDATE_SIZE);
    localparam logic [CREDIT_BITS:0]   CredMax  = (CREDIT_BITS + 1)'(CREDIT_INIT);
    localparam logic [CREDIT_BITS-1:0] CredInit = CREDIT_BITS'(CREDIT_INIT);

    dest_entry_t                cfg_q    [NUM_OUT_PORTS];
    dest_entry_t                cfg_d    [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]     credit_q [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]     credit_d [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0]   seq_q    [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0]   seq_d    [NUM_OUT_PORTS];
    logic [PtrW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PACKET_BITS-1:0]     dout_q, dout_d;

    logic                       load;
    logic [NUM_OUT_PORTS-1:0]   req, gnt;
    logic                       gnt_any;
    logic [PtrW-1:0]            gnt_idx;
    logic [PAYLOAD_BITS-1:0]    gnt_word;
    logic [NUM_LEAF_BITS-1:0]   gnt_leaf;
    logic [NUM_PORT_BITS-1:0]   gnt_dport;
    logic [NUM_ADDR_BITS-1:0]   gnt_seq;

    // Output register can take a new packet when empty or being drained.
    always_comb begin
        load = !dout_q[VALID_BIT] || out_ready;
        req  = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            req[i] = load && !resend && vld_user2interface[i] && cfg_q[i].configured
                     && (credit_q[i] != '0);
        end
    end

    rr_arbiter #(
        .N    (NUM_OUT_PORTS),
        .PtrW (PtrW)
    ) u_rr_arbiter (
        .req_i (req),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt)
    );

    assign ack_interface2user      = gnt;
    assign gnt_any                 = |gnt;
    assign dout_leaf_interface2bft = dout_q;

    always_comb begin
        gnt_idx   = '0;
        gnt_word  = '0;
        gnt_leaf  = '0;
        gnt_dport = '0;
        gnt_seq   = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (gnt[i]) begin
                gnt_idx   = PtrW'(i);
                gnt_word  = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                gnt_leaf  = cfg_q[i].leaf;
                gnt_dport = cfg_q[i].dport;
                gnt_seq   = seq_q[i];
            end
        end
    end

    always_comb begin
        logic [CREDIT_BITS:0] sum;
        dout_d   = dout_q;
        rr_ptr_d = rr_ptr_q;
        sum      = '0;
        cfg_d    = cfg_q;
        credit_d = credit_q;
        seq_d    = seq_q;

        if (resend) begin
            dout_d[VALID_BIT] = 1'b0;
        end else if (gnt_any) begin
            dout_d[VALID_BIT]                    = 1'b1;
            dout_d[LEAF_LSB +: NUM_LEAF_BITS]    = gnt_leaf;
            dout_d[PORT_LSB +: NUM_PORT_BITS]    = gnt_dport;
            dout_d[ADDR_LSB +: NUM_ADDR_BITS]    = gnt_seq;
            dout_d[PAYLOAD_BITS-1:0]             = gnt_word;
            rr_ptr_d                             = gnt_idx;
        end else if (out_ready) begin
            dout_d[VALID_BIT] = 1'b0;
        end

        // Out-of-range cfg_port / credit_upd_port never match an index.
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (gnt[i]) begin
                seq_d[i] = seq_q[i] + 1'b1;
            end
            sum = {1'b0, credit_q[i]};
            if (credit_upd && (credit_upd_port == NUM_PORT_BITS'(i))) begin
                sum = sum + UpdAmt;
            end
            if (gnt[i]) begin
                sum = sum - 1'b1;
            end
            if (sum > CredMax) begin
                sum = CredMax;
            end
            credit_d[i] = sum[CREDIT_BITS-1:0];
            if (cfg_wr && (cfg_port == NUM_PORT_BITS'(i))) begin
                cfg_d[i].leaf       = cfg_leaf;
                cfg_d[i].dport      = cfg_dport;
                cfg_d[i].configured = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q   <= '0;
            rr_ptr_q <= PtrW'(NUM_OUT_PORTS - 1);
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                cfg_q[i]    <= '0;
                credit_q[i] <= CredInit;
                seq_q[i]    <= '0;
            end
        end else begin
            dout_q   <= dout_d;
            rr_ptr_q <= rr_ptr_d;
            cfg_q    <= cfg_d;
            credit_q <= credit_d;
            seq_q    <= seq_d;
        end
    end

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Randomised bench for leaf_out_arbiter: a reference model predicts acks and
// packets into queues; a monitor pops and compares as the DUT presents them.
module tb_leaf_out_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [95:0] din;
    logic [2:0]  vld;
    logic [2:0]  ack;
    logic        cfg_wr, credit_upd, resend, out_ready;
    logic [3:0]  cfg_port, cfg_dport, credit_upd_port;
    logic [4:0]  cfg_leaf;
    logic [48:0] dout;

    always #5 clk = ~clk;

    leaf_out_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .cfg_wr                  (cfg_wr),
        .cfg_port                (cfg_port),
        .cfg_leaf                (cfg_leaf),
        .cfg_dport               (cfg_dport),
        .credit_upd              (credit_upd),
        .credit_upd_port         (credit_upd_port),
        .resend                  (resend),
        .out_ready               (out_ready),
        .dout_leaf_interface2bft (dout)
    );

    logic [48:0] pq[$];
    logic [2:0]  aq[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          ack1_cnt = 0;
    logic [2:0]  mon_ea;

    // Stimulus staged by the sequence, applied by step().
    logic [2:0]  s_vld;
    logic [95:0] s_din;
    logic        s_rdy, s_rs, s_cw, s_cu;
    logic [3:0]  s_cp, s_cd, s_cup;
    logic [4:0]  s_cl;

    // Reference model state.
    int          m_credit[3];
    bit          m_cfg[3];
    logic [4:0]  m_leaf[3];
    logic [3:0]  m_dport[3];
    int          m_seq[3];
    int          m_last;
    bit          m_dvalid;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        s_vld = '0; s_din = '0; s_rdy = 1'b1; s_rs = 1'b0; s_cw = 1'b0; s_cu = 1'b0;
        s_cp = '0; s_cd = '0; s_cup = '0; s_cl = '0;
    endtask

    task automatic step();
        int g;
        int p;
        @(posedge clk);
        #1;
        vld = s_vld; din = s_din; out_ready = s_rdy; resend = s_rs;
        cfg_wr = s_cw; cfg_port = s_cp; cfg_leaf = s_cl; cfg_dport = s_cd;
        credit_upd = s_cu; credit_upd_port = s_cup;

        g = -1;
        if ((!m_dvalid || s_rdy) && !s_rs) begin
            for (int k = 1; k <= 3; k++) begin
                p = (m_last + k) % 3;
                if (g < 0 && s_vld[p] && m_cfg[p] && m_credit[p] > 0) g = p;
            end
        end
        aq.push_back(g >= 0 ? 3'(1 << g) : 3'b000);

        if (g >= 0) begin
            pq.push_back({1'b1, m_leaf[g], m_dport[g], 7'(m_seq[g]), s_din[g*32 +: 32]});
            m_seq[g] = (m_seq[g] + 1) % 128;
            m_credit[g]--;
            m_last   = g;
            m_dvalid = 1'b1;
        end else if (s_rs) begin
            if (m_dvalid && !s_rdy) pq.delete(pq.size() - 1);
            m_dvalid = 1'b0;
        end else if (s_rdy) begin
            m_dvalid = 1'b0;
        end

        if (s_cu && s_cup < 3) begin
            m_credit[s_cup] = m_credit[s_cup] + 64;
            if (m_credit[s_cup] > 128) m_credit[s_cup] = 128;
        end
        if (s_cw && s_cp < 3) begin
            m_cfg[s_cp]   = 1'b1;
            m_leaf[s_cp]  = s_cl;
            m_dport[s_cp] = s_cd;
        end
    endtask

    task automatic check_count(input string name, input int exp);
        @(negedge clk);
        #1;
        chk(name, 64'(ack1_cnt), 64'(exp));
        ack1_cnt = 0;
    endtask

    // Monitor: one ack expectation per cycle; a packet is consumed when valid & ready.
    initial begin
        forever begin
            @(negedge clk);
            if (aq.size() > 0) begin
                mon_ea = aq.pop_front();
                chk("ack", 64'(ack), 64'(mon_ea));
                if (ack[1]) ack1_cnt++;
            end
            if (reset && dout[48] && out_ready) begin
                if (pq.size() == 0) chk("unexpected_pkt", 64'(dout), 64'(0));
                else chk("packet", 64'(dout), 64'(pq.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        reset = 1'b0;
        vld = 3'b111; din = '0; out_ready = 1'b1; resend = 1'b0;
        cfg_wr = 1'b0; cfg_port = '0; cfg_leaf = '0; cfg_dport = '0;
        credit_upd = 1'b0; credit_upd_port = '0;
        for (int i = 0; i < 3; i++) begin
            m_credit[i] = 128; m_cfg[i] = 1'b0; m_leaf[i] = '0; m_dport[i] = '0; m_seq[i] = 0;
        end
        m_last = 2; m_dvalid = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_dout", 64'(dout), 64'(0));
        chk("reset_ack", 64'(ack), 64'(0));
        @(posedge clk);
        #1;
        vld = '0;
        reset = 1'b1;

        // First packet: port0 -> leaf 3 / port 2.
        set_idle(); s_cw = 1'b1; s_cp = 4'd0; s_cl = 5'd3; s_cd = 4'd2; step();
        set_idle(); s_vld = 3'b001; s_din[31:0] = 32'hDEADBEEF; step();
        set_idle(); step();
        #2;
        chk("first_pkt", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));

        // Unconfigured port2 stays idle until its config lands.
        set_idle(); s_vld = 3'b100; s_din = {$urandom, $urandom, $urandom};
        repeat (3) step();
        s_cw = 1'b1; s_cp = 4'd2; s_cl = 5'd7; s_cd = 4'd9; step();
        s_cw = 1'b0; step();
        set_idle(); s_cw = 1'b1; s_cp = 4'd1; s_cl = 5'd17; s_cd = 4'd5; step();

        // Round robin across all three ports.
        set_idle(); s_vld = 3'b111;
        repeat (6) begin s_din = {$urandom, $urandom, $urandom}; step(); end

        // Back-pressure hold, then release.
        s_rdy = 1'b0; repeat (5) step();
        s_rdy = 1'b1; repeat (3) step();

        // Resend drops a held packet and freezes arbitration.
        s_rdy = 1'b0; step();
        s_rs = 1'b1; repeat (2) step();
        s_rs = 1'b0; s_rdy = 1'b1; repeat (4) step();

        // Credit exhaustion and return on port1.
        set_idle(); s_cu = 1'b1; s_cup = 4'd1; step(); step();
        s_cu = 1'b0;
        @(negedge clk); #1; ack1_cnt = 0;
        s_vld = 3'b010; repeat (135) step();
        check_count("port1_credit_128", 128);
        s_vld = 3'b000; s_cu = 1'b1; step();
        s_cu = 1'b0; s_vld = 3'b010; repeat (70) step();
        check_count("port1_after_upd", 64);
        s_vld = 3'b000; s_cu = 1'b1; step();
        s_cu = 1'b0; s_vld = 3'b010; repeat (63) step();
        check_count("port1_63", 63);
        s_cu = 1'b1; step();
        s_cu = 1'b0; repeat (70) step();
        check_count("port1_coincident", 65);

        // Randomised traffic including out-of-range config/credit ports.
        repeat (2000) begin
            s_vld = 3'($urandom);
            s_din = {$urandom, $urandom, $urandom};
            s_rdy = ($urandom_range(9) < 7);
            s_rs  = ($urandom_range(19) == 0);
            s_cw  = ($urandom_range(19) == 0);
            s_cp  = 4'($urandom_range(4));
            s_cl  = 5'($urandom);
            s_cd  = 4'($urandom);
            s_cu  = ($urandom_range(9) == 0);
            s_cup = 4'($urandom_range(3));
            step();
        end

        set_idle(); repeat (4) step();
        @(negedge clk); #1;
        chk("queue_empty", 64'(pq.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
